// File: rtl/serial_add_arb.sv
// ---------------------------------------------------------------------------
// serial_add_arb
//
// Two requesters share one bit-serial adder. The adder is a single 1-bit
// slice built from two half adders. It processes one operand bit per cycle,
// starting at the LSB. When both requesters ask in the same cycle, a
// round-robin pointer settles the tie. Operands are captured in the cycle
// the grant is issued. A WIDTH-bit add takes WIDTH cycles in ADD, followed
// by one DONE cycle that presents the result.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        synchronous, active-high reset
//   req0_i       requester 0 request (held until granted)
//   a0_i, b0_i   requester 0 operands
//   req1_i       requester 1 request (held until granted)
//   a1_i, b1_i   requester 1 operands
//   gnt_o        one-hot grant, combinational while idle
//   busy_o       high whenever an operation is in flight
//   res_valid_o  one-cycle pulse marking a fresh result
//   res_id_o     requester that owns the current result
//   res_sum_o    sum modulo 2^WIDTH (held until the next result)
//   res_cout_o   carry out of the top bit (held until the next result)
// ---------------------------------------------------------------------------
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic [1:0]       gnt_o,
    output logic             busy_o,
    output logic             res_valid_o,
    output logic             res_id_o,
    output logic [WIDTH-1:0] res_sum_o,
    output logic             res_cout_o
);

    localparam int IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic             owner_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic             carry_q;
    logic [IdxW-1:0]  idx_q;
    logic             resValid_q;
    logic             resId_q;
    logic [WIDTH-1:0] resSum_q;
    logic             resCout_q;

    logic [1:0]       gnt_d;
    logic             bitA;
    logic             bitB;
    logic             ha1Sum;
    logic             ha1Carry;
    logic             ha2Carry;
    logic             sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] opA_d;
    logic [WIDTH-1:0] opB_d;

    // Grant decision. prio_q names the requester that wins a tie. That is
    // the one not granted most recently. Reset holds the grant low, so a
    // request in a reset cycle is never granted.
    always_comb begin
        gnt_d = 2'b00;
        if (!rst_i && state_q == IDLE) begin
            if (req0_i && req1_i) begin
                gnt_d = prio_q ? 2'b10 : 2'b01;
            end else if (req0_i) begin
                gnt_d = 2'b01;
            end else if (req1_i) begin
                gnt_d = 2'b10;
            end
        end
    end

    // Shared 1-bit slice made of two half adders. The sum bit is shifted in
    // at the top of the A register as the A bits shift out at the bottom.
    // After WIDTH steps, the A register holds the complete sum.
    always_comb begin
        bitA     = opA_q[0];
        bitB     = opB_q[0];
        ha1Sum   = bitA ^ bitB;
        ha1Carry = bitA & bitB;
        sum_d    = ha1Sum ^ carry_q;
        ha2Carry = ha1Sum & carry_q;
        carry_d  = ha1Carry | ha2Carry;
        opA_d    = {sum_d, opA_q[WIDTH-1:1]};
        opB_d    = {1'b0, opB_q[WIDTH-1:1]};
    end

    // Controller and datapath registers. Result registers change only on
    // the edge into DONE, so they hold from one result pulse to the next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            resValid_q <= 1'b0;
            resId_q    <= 1'b0;
            resSum_q   <= '0;
            resCout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resValid_q <= 1'b0;
                    if (gnt_d != 2'b00) begin
                        opA_q   <= gnt_d[1] ? a1_i : a0_i;
                        opB_q   <= gnt_d[1] ? b1_i : b0_i;
                        owner_q <= gnt_d[1];
                        prio_q  <= gnt_d[0];
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    opA_q   <= opA_d;
                    opB_q   <= opB_d;
                    carry_q <= carry_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        resValid_q <= 1'b1;
                        resSum_q   <= opA_d;
                        resCout_q  <= carry_d;
                        resId_q    <= owner_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    resValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_d;
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = resValid_q;
    assign res_id_o    = resId_q;
    assign res_sum_o   = resSum_q;
    assign res_cout_o  = resCout_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// ---------------------------------------------------------------------------
// tb_serial_add_arb
//
// Bench for the shared bit-serial adder with its round-robin arbiter.
//
// The reference is a timing model. A grant in cycle T makes the unit busy
// up to and including cycle T+WIDTH+1. The result a+b appears in cycle
// T+WIDTH+1. A tie goes to the requester that did not win last time.
// The model and the DUT are compared in every cycle on the falling edge.
// Directed sequences check fixed literal results. A randomized phase
// follows them.
// ---------------------------------------------------------------------------
module tb_serial_add_arb;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [1:0]       gnt;
   logic             busy;
   logic             resValid;
   logic             resId;
   logic [WIDTH-1:0] resSum;
   logic             resCout;

   int assertCount = 0;
   int failCount   = 0;

   serial_add_arb #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req0_i     (req0),
      .a0_i       (a0),
      .b0_i       (b0),
      .req1_i     (req1),
      .a1_i       (a1),
      .b1_i       (b1),
      .gnt_o      (gnt),
      .busy_o     (busy),
      .res_valid_o(resValid),
      .res_id_o   (resId),
      .res_sum_o  (resSum),
      .res_cout_o (resCout)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive both requester ports.
   task automatic applyStimulus(input logic r0, input logic [WIDTH-1:0] x0,
                                input logic [WIDTH-1:0] y0, input logic r1,
                                input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1);
      req0 = r0; a0 = x0; b0 = y0;
      req1 = r1; a1 = x1; b1 = y1;
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) tick();
   endtask

   // Reference model state, kept in cycle numbers rather than FSM states.
   int               cyc       = 0;
   int               idleFrom  = 0;
   bit               started   = 0;
   bit               pend      = 0;
   int               pendCycle = 0;
   logic [WIDTH-1:0] pendSum;
   logic             pendCout;
   logic             pendId;
   logic             mPrio     = 1'b0;
   logic [WIDTH-1:0] mSum      = '0;
   logic             mCout     = 1'b0;
   logic             mId       = 1'b0;

   // Per-cycle model step and comparison on the falling edge.
   always @(negedge clk) begin
      logic [1:0]     expGnt;
      logic           expBusy;
      logic           expValid;
      logic [WIDTH:0] total;
      if (rst) begin
         checkOutput("gnt_during_reset", 32'(gnt), 32'(2'b00));
         started  = 1;
         idleFrom = cyc + 1;
         pend     = 0;
         mPrio    = 1'b0;
         mSum     = '0;
         mCout    = 1'b0;
         mId      = 1'b0;
      end else if (started) begin
         expBusy  = (cyc < idleFrom);
         expValid = pend && (cyc == pendCycle);
         if (expValid) begin
            mSum  = pendSum;
            mCout = pendCout;
            mId   = pendId;
            pend  = 0;
         end
         expGnt = 2'b00;
         if (!expBusy) begin
            if (req0 && req1) expGnt = mPrio ? 2'b10 : 2'b01;
            else if (req0)    expGnt = 2'b01;
            else if (req1)    expGnt = 2'b10;
         end
         if (expGnt != 2'b00) begin
            pendId    = expGnt[1];
            total     = pendId ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            pendSum   = total[WIDTH-1:0];
            pendCout  = total[WIDTH];
            pendCycle = cyc + WIDTH + 1;
            pend      = 1;
            idleFrom  = cyc + WIDTH + 2;
            mPrio     = ~pendId;
         end
         checkOutput("model_gnt",      32'(gnt),      32'(expGnt));
         checkOutput("model_busy",     32'(busy),     32'(expBusy));
         checkOutput("model_resValid", 32'(resValid), 32'(expValid));
         checkOutput("model_resSum",   32'(resSum),   32'(mSum));
         checkOutput("model_resCout",  32'(resCout),  32'(mCout));
         checkOutput("model_resId",    32'(resId),    32'(mId));
      end
      cyc++;
   end

   // Directed sequences with literal expectations, then random traffic.
   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(2);
      rst = 1'b0;

      // Single operation: 0x35 + 0x4A.
      applyStimulus(1, 8'h35, 8'h4A, 0, 0, 0);
      #3 checkOutput("single_gnt", 32'(gnt), 32'(2'b01));
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(8);
      #3;
      checkOutput("single_valid", 32'(resValid), 32'd1);
      checkOutput("single_sum",   32'(resSum),   32'h7F);
      checkOutput("single_cout",  32'(resCout),  32'd0);
      checkOutput("single_id",    32'(resId),    32'd0);
      tick();
      #3;
      checkOutput("single_pulse_end", 32'(resValid), 32'd0);
      checkOutput("single_sum_hold",  32'(resSum),   32'h7F);

      // Overflow on requester 1: 0xFF + 0x01.
      tick();
      applyStimulus(0, 0, 0, 1, 8'hFF, 8'h01);
      #3 checkOutput("ovf_gnt", 32'(gnt), 32'(2'b10));
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(8);
      #3;
      checkOutput("ovf_valid", 32'(resValid), 32'd1);
      checkOutput("ovf_sum",   32'(resSum),   32'h00);
      checkOutput("ovf_cout",  32'(resCout),  32'd1);
      checkOutput("ovf_id",    32'(resId),    32'd1);
      tick();

      // Tie after reset: grants alternate 0, 1, 0 at cycles 0, 10, 20.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) tick();
         if (c == 0)  applyStimulus(1, 8'h01, 8'h02, 1, 8'h30, 8'h40);
         if (c == 21) applyStimulus(0, 0, 0, 0, 0, 0);
         #3;
         if (c == 0)  checkOutput("tie_gnt_c0",  32'(gnt), 32'(2'b01));
         if (c == 5)  checkOutput("tie_gnt_busy", 32'(gnt), 32'(2'b00));
         if (c == 10) checkOutput("tie_gnt_c10", 32'(gnt), 32'(2'b10));
         if (c == 20) checkOutput("tie_gnt_c20", 32'(gnt), 32'(2'b01));
         if (c == 9) begin
            checkOutput("tie_id_c9",  32'(resId),  32'd0);
            checkOutput("tie_sum_c9", 32'(resSum), 32'h03);
         end
         if (c == 19) begin
            checkOutput("tie_id_c19",  32'(resId),  32'd1);
            checkOutput("tie_sum_c19", 32'(resSum), 32'h70);
         end
         if (c == 29) begin
            checkOutput("tie_valid_c29", 32'(resValid), 32'd1);
            checkOutput("tie_id_c29",    32'(resId),    32'd0);
         end
      end

      // Busy ignore: req1 rises in cycle 3 and is granted in cycle 10.
      tick();
      applyStimulus(1, 8'h10, 8'h22, 0, 0, 0);
      #3 checkOutput("busy_gnt0", 32'(gnt), 32'(2'b01));
      tick();
      applyStimulus(0, 8'hAA, 8'hBB, 0, 0, 0);
      tick();
      tick();
      applyStimulus(0, 0, 0, 1, 8'h05, 8'h06);
      for (int c = 3; c <= 9; c++) begin
         if (c > 3) tick();
         #3 checkOutput("busy_gnt_low", 32'(gnt), 32'(2'b00));
      end
      checkOutput("busy_sum0", 32'(resSum), 32'h32);
      checkOutput("busy_id0",  32'(resId),  32'd0);
      tick();
      #3 checkOutput("busy_gnt1", 32'(gnt), 32'(2'b10));
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(8);
      #3;
      checkOutput("busy_sum1", 32'(resSum), 32'h0B);
      checkOutput("busy_id1",  32'(resId),  32'd1);
      tick();

      // Mid-operation reset in cycle 5 aborts the add.
      applyStimulus(1, 8'h11, 8'h22, 0, 0, 0);
      #3 checkOutput("abort_gnt", 32'(gnt), 32'(2'b01));
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #3;
      checkOutput("abort_busy", 32'(busy),   32'd0);
      checkOutput("abort_sum",  32'(resSum), 32'h00);
      for (int c = 6; c <= 12; c++) begin
         if (c > 6) tick();
         #3 checkOutput("abort_no_valid", 32'(resValid), 32'd0);
      end
      tick();
      applyStimulus(1, 8'h40, 8'h41, 0, 0, 0);
      #3 checkOutput("abort_regnt", 32'(gnt), 32'(2'b01));
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(8);
      #3;
      checkOutput("abort_resum", 32'(resSum),   32'h81);
      checkOutput("abort_valid", 32'(resValid), 32'd1);
      tick();

      // Operand hold: operands change every cycle after the grant.
      applyStimulus(1, 8'h9C, 8'h77, 0, 0, 0);
      #3 checkOutput("hold_gnt", 32'(gnt), 32'(2'b01));
      for (int c = 1; c <= 9; c++) begin
         tick();
         applyStimulus(0, 8'($urandom), 8'($urandom), 0, 0, 0);
      end
      #3;
      checkOutput("hold_sum",  32'(resSum),  32'h13);
      checkOutput("hold_cout", 32'(resCout), 32'd1);
      tick();

      // Random traffic, with occasional resets and dropped requests.
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         applyStimulus($urandom_range(0, 4) < 2, 8'($urandom), 8'($urandom),
                       $urandom_range(0, 4) < 2, 8'($urandom), 8'($urandom));
         tick();
      end
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      waitCycles(12);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 operation request; held high until granted.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands; valid while req0 high.
REQ-006 req1  input  1  requester 1 operation request; held high until granted.
REQ-007 a1, b1  input  WIDTH each  requester 1 operands; valid while req1 high.
REQ-008 gnt  output  2  one-hot grant; combinational in IDLE; bit i high for exactly the cycle requester i's operands are captured.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 res_valid  output  1  one-cycle pulse; result outputs are valid.
REQ-011 res_id  output  1  index of the requester owning the current result.
REQ-012 res_sum  output  WIDTH  sum modulo 2^WIDTH.
REQ-013 res_cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 Block SHALL share one 1-bit adder slice, built from two half-adder stages (s=a^b, c=a&b), between both requesters; one bit per cycle, LSB first.
REQ-015 States SHALL be IDLE, ADD, DONE.
REQ-016 IDLE with no req: gnt=0, remain IDLE.
REQ-017 IDLE with exactly one req high: grant that requester, capture its operands, clear carry and bit index, go to ADD next cycle.
REQ-018 IDLE with both reqs high: grant the requester not granted most recently; after reset requester 0 wins the first tie.
REQ-019 Round-robin pointer SHALL update only on a grant.
REQ-020 ADD: each cycle compute bit idx: sum=a^b^c, carry_next=(a&b)|(c&(a^b)); store sum bit; idx increments.
REQ-021 ADD SHALL last exactly WIDTH cycles; after bit WIDTH-1 go to DONE.
REQ-022 DONE: res_valid=1 for one cycle with res_sum, res_cout, res_id updated in the same cycle; next state IDLE.
REQ-023 Latency: gnt in cycle T -> res_valid in cycle T+WIDTH+1; earliest next gnt in cycle T+WIDTH+2.
REQ-024 res_sum, res_cout, res_id SHALL hold their values from res_valid until the next DONE.
REQ-025 req inputs and operands SHALL be ignored while busy; gnt=0 outside IDLE.
REQ-026 A req dropped before its grant SHALL leave no effect; no partial operation.
REQ-027 Overflow SHALL wrap: res_sum=(a+b) mod 2^WIDTH, res_cout=bit WIDTH of a+b.
REQ-028 Operand changes after grant SHALL not affect the in-flight result.

Reset
REQ-029 While rst=1 at a rising edge: state IDLE, gnt=0, busy=0, res_valid=0, res_id=0, res_sum=0, res_cout=0, carry=0, idx=0, pointer favours requester 0.
REQ-030 Reset during ADD or DONE SHALL abort the operation; no res_valid for it; the requester must re-request.
REQ-031 rst SHALL take priority over any req in the same cycle.

Verification
REQ-032 Single op: WIDTH=8, req0=1, a0=0x35, b0=0x4A -> gnt=01 cycle 0; res_valid cycle 9, res_sum=0x7F, res_cout=0, res_id=0.
REQ-033 Overflow: req1, a1=0xFF, b1=0x01 -> res_sum=0x00, res_cout=1, res_id=1, 9 cycles after gnt=10.
REQ-034 Tie and fairness: req0=req1=1 held after reset -> grants 01, 10, 01 in cycles 0, 10, 20; res_id sequence 0,1,0.
REQ-035 Busy ignore: req1 rises in cycle 3 during req0's ADD -> gnt=0 until cycle 10, then gnt=10; req0's result unaffected.
REQ-036 Mid-op reset: rst=1 in cycle 5 of an ADD -> next cycle busy=0, res_valid never pulses, res_sum=0; fresh req0 then completes normally.
REQ-037 Operand hold: after gnt, change a0/b0 each cycle -> res_sum equals the sum of the values captured at grant.
